// File: rtl/rv32i_exec_core_if.sv
// Instruction-fetch bus between the execution core and program memory.
// The core drives the byte address and read strobe. Memory returns the
// instruction word on the cycle after the strobe.
interface rv32i_exec_core_if;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_rstrb,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_rstrb,
      output mem_rdata
   );
endinterface

// File: rtl/rv32i_exec_core.sv
// Multi-cycle RV32I execution core with four cycles per instruction:
// fetch, wait, register read and execute.
// ALU, LUI, AUIPC, JAL, JALR and branch instructions execute.
// Load, store, FENCE and unknown opcodes retire without side effects.
// A SYSTEM opcode stops the core until the next reset.
module rv32i_exec_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      CLK,
   input  logic                      RESET,
   rv32i_exec_core_if.master         mem,
   output logic                      retire,
   output logic                      halt,
   output logic [31:0]               dbg_x1
);

   localparam logic [2:0] S_FETCH_INSTR = 3'd0;
   localparam logic [2:0] S_WAIT_INSTR  = 3'd1;
   localparam logic [2:0] S_FETCH_REGS  = 3'd2;
   localparam logic [2:0] S_EXECUTE     = 3'd3;
   localparam logic [2:0] S_HALT        = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_rs1;
   logic [31:0] r_rs2;
   logic        r_halt;
   logic [31:0] r_regs [0:31];

   // Field decode from the latched instruction word
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1_idx;
   logic [4:0]  w_rs2_idx;
   logic [2:0]  w_funct3;
   logic        w_is_alureg, w_is_aluimm, w_is_branch, w_is_jal, w_is_jalr;
   logic        w_is_lui, w_is_auipc, w_is_system;
   logic [31:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;

   assign w_opcode    = r_instr[6:0];
   assign w_rd        = r_instr[11:7];
   assign w_funct3    = r_instr[14:12];
   assign w_rs1_idx   = r_instr[19:15];
   assign w_rs2_idx   = r_instr[24:20];

   assign w_is_alureg = (w_opcode == 7'b0110011);
   assign w_is_aluimm = (w_opcode == 7'b0010011);
   assign w_is_branch = (w_opcode == 7'b1100011);
   assign w_is_jalr   = (w_opcode == 7'b1100111);
   assign w_is_jal    = (w_opcode == 7'b1101111);
   assign w_is_auipc  = (w_opcode == 7'b0010111);
   assign w_is_lui    = (w_opcode == 7'b0110111);
   assign w_is_system = (w_opcode == 7'b1110011);

   assign w_imm_i = {{21{r_instr[31]}}, r_instr[30:20]};
   assign w_imm_b = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
   assign w_imm_u = {r_instr[31:12], 12'b0};
   assign w_imm_j = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};

   // ALU operand 2 is the rs2 value for register ops and the I immediate otherwise
   logic [31:0] w_alu_in2;
   logic [4:0]  w_shamt;
   logic [31:0] w_alu_out;

   assign w_alu_in2 = w_is_alureg ? r_rs2 : w_imm_i;
   assign w_shamt   = w_alu_in2[4:0];

   // ALU operation selected by funct3. instr[30] chooses SUB for register ops and SRA for both op types.
   always_comb begin
      w_alu_out = 32'd0;
      case (w_funct3)
         3'b000: w_alu_out = (w_is_alureg && r_instr[30]) ? (r_rs1 - w_alu_in2) : (r_rs1 + w_alu_in2);
         3'b001: w_alu_out = r_rs1 << w_shamt;
         3'b010: w_alu_out = {31'd0, ($signed(r_rs1) < $signed(w_alu_in2))};
         3'b011: w_alu_out = {31'd0, (r_rs1 < w_alu_in2)};
         3'b100: w_alu_out = r_rs1 ^ w_alu_in2;
         3'b101: w_alu_out = r_instr[30] ? 32'($signed(r_rs1) >>> w_shamt) : (r_rs1 >> w_shamt);
         3'b110: w_alu_out = r_rs1 | w_alu_in2;
         default: w_alu_out = r_rs1 & w_alu_in2;
      endcase
   end

   // Branch condition. funct3 010 and 011 are not valid branches and are never taken.
   logic w_take_branch;
   always_comb begin
      w_take_branch = 1'b0;
      case (w_funct3)
         3'b000: w_take_branch = (r_rs1 == r_rs2);
         3'b001: w_take_branch = (r_rs1 != r_rs2);
         3'b100: w_take_branch = ($signed(r_rs1) <  $signed(r_rs2));
         3'b101: w_take_branch = ($signed(r_rs1) >= $signed(r_rs2));
         3'b110: w_take_branch = (r_rs1 <  r_rs2);
         3'b111: w_take_branch = (r_rs1 >= r_rs2);
         default: w_take_branch = 1'b0;
      endcase
   end

   // Writeback data and next-PC selection
   logic [31:0] w_pc_plus4;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_pc_next;
   logic [31:0] w_wb_data;
   logic        w_wb_en;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_jalr_sum = r_rs1 + w_imm_i;

   // Only ALU, upper-immediate and jump instructions write a register. Writes to x0 are discarded.
   always_comb begin
      w_wb_en   = (w_is_alureg || w_is_aluimm || w_is_lui || w_is_auipc || w_is_jal || w_is_jalr)
                  && (w_rd != 5'd0);
      w_wb_data = w_alu_out;
      if (w_is_lui)
         w_wb_data = w_imm_u;
      else if (w_is_auipc)
         w_wb_data = r_pc + w_imm_u;
      else if (w_is_jal || w_is_jalr)
         w_wb_data = w_pc_plus4;
   end

   // JALR uses the rs1 value latched in FETCH_REGS, so rd == rs1 cannot corrupt the target.
   always_comb begin
      w_pc_next = w_pc_plus4;
      if (w_is_jal)
         w_pc_next = r_pc + w_imm_j;
      else if (w_is_jalr)
         w_pc_next = {w_jalr_sum[31:1], 1'b0};
      else if (w_is_branch && w_take_branch)
         w_pc_next = r_pc + w_imm_b;
   end

   // Sequencer, register-file read and writeback. Reset also drops any pending writeback.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_FETCH_INSTR;
         r_pc    <= RESET_PC;
         r_instr <= 32'd0;
         r_rs1   <= 32'd0;
         r_rs2   <= 32'd0;
         r_halt  <= 1'b0;
         for (int i = 0; i < 32; i++)
            r_regs[i] <= 32'd0;
      end else begin
         case (r_state)
            S_FETCH_INSTR: r_state <= S_WAIT_INSTR;
            S_WAIT_INSTR: begin
               r_instr <= mem.mem_rdata;
               r_state <= S_FETCH_REGS;
            end
            S_FETCH_REGS: begin
               r_rs1   <= (w_rs1_idx == 5'd0) ? 32'd0 : r_regs[w_rs1_idx];
               r_rs2   <= (w_rs2_idx == 5'd0) ? 32'd0 : r_regs[w_rs2_idx];
               r_state <= S_EXECUTE;
            end
            S_EXECUTE: begin
               if (w_wb_en)
                  r_regs[w_rd] <= w_wb_data;
               r_pc    <= w_pc_next;
               r_halt  <= w_is_system;
               r_state <= w_is_system ? S_HALT : S_FETCH_INSTR;
            end
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_FETCH_INSTR;
         endcase
      end
   end

   assign mem.mem_addr  = r_pc;
   assign mem.mem_rstrb = (r_state == S_FETCH_INSTR);
   assign retire        = (r_state == S_EXECUTE);
   assign halt          = r_halt;
   assign dbg_x1        = r_regs[1];

endmodule

// File: tb/tb_rv32i_exec_core.sv
// Bench for rv32i_exec_core.
// Stimulus loads short programs and pushes the expected result of each retirement.
// A monitor pops one expectation per retire pulse.
// It compares the instruction PC and the cycle number, then compares x1 on the following cycle.
module tb_rv32i_exec_core;

   logic        CLK;
   logic        RESET;
   logic        retire;
   logic        halt;
   logic [31:0] dbg_x1;

   rv32i_exec_core_if bus ();

   rv32i_exec_core #(.RESET_PC(32'h0000_0000)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .mem    (bus.master),
      .retire (retire),
      .halt   (halt),
      .dbg_x1 (dbg_x1)
   );

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] x1;
      int          cyc;
   } exp_t;

   exp_t        sbq [$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          k_ret = 0;
   logic [31:0] imem [0:63];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Program memory with registered read, one cycle after the strobe
   always @(posedge CLK) begin
      if (bus.mem_rstrb)
         bus.mem_rdata <= imem[bus.mem_addr[7:2]];
   end

   // Cycle index, where 0 is the cycle after the last reset edge
   always @(posedge CLK) begin
      if (RESET) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Monitor: pop one expectation per retire pulse and check x1 one cycle later
   logic        pend = 1'b0;
   logic [31:0] pend_x1;
   logic [31:0] pend_pc;
   always @(negedge CLK) begin
      exp_t e;
      if (pend) begin
         total++;
         if (dbg_x1 !== pend_x1) begin
            bad++;
            $display("FAIL sb_x1 pc=%h actual=%h required=%h", pend_pc, dbg_x1, pend_x1);
         end
         pend = 1'b0;
      end
      if (retire === 1'b1) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow retire at pc=%h with nothing expected", bus.mem_addr);
         end else begin
            e = sbq.pop_front();
            if (bus.mem_addr !== e.pc || cyc != e.cyc) begin
               bad++;
               $display("FAIL sb_retire actual pc=%h cyc=%0d required pc=%h cyc=%0d",
                        bus.mem_addr, cyc, e.pc, e.cyc);
            end else begin
               $display("retire pc=%h cyc=%0d x1_exp=%h", e.pc, cyc, e.x1);
            end
            pend    = 1'b1;
            pend_x1 = e.x1;
            pend_pc = e.pc;
         end
      end
   end

   task automatic expect_ret(input logic [31:0] pc, input logic [31:0] x1);
      exp_t e;
      e.pc  = pc;
      e.x1  = x1;
      e.cyc = 3 + 4 * k_ret;
      k_ret++;
      sbq.push_back(e);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) imem[i] = EBREAK;
   endtask

   // Called at a negedge; applies reset for one edge and checks the reset state while RESET is held
   task automatic do_reset();
      RESET = 1'b1;
      @(negedge CLK);
      total++;
      if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'd0 || retire !== 1'b0 ||
          halt !== 1'b0 || dbg_x1 !== 32'd0) begin
         bad++;
         $display("FAIL reset_state actual rstrb=%b addr=%h retire=%b halt=%b x1=%h required 1,0,0,0,0",
                  bus.mem_rstrb, bus.mem_addr, retire, halt, dbg_x1);
      end else begin
         $display("reset state ok");
      end
      k_ret = 0;
      RESET = 1'b0;
   endtask

   // Wait for halt with a cycle budget, then check that the core stays frozen
   task automatic finish_prog(input string name);
      int          n;
      logic [31:0] addr0;
      n = 0;
      while (halt !== 1'b1 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      total++;
      if (halt !== 1'b1) begin
         bad++;
         $display("FAIL %s_halt_timeout actual halt=%b required 1", name, halt);
      end
      @(negedge CLK);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL %s_sb_left actual=%0d required 0", name, sbq.size());
         sbq.delete();
      end
      addr0 = bus.mem_addr;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         total++;
         if (halt !== 1'b1 || bus.mem_rstrb !== 1'b0 || retire !== 1'b0 || bus.mem_addr !== addr0) begin
            bad++;
            $display("FAIL %s_halt_hold actual halt=%b rstrb=%b retire=%b addr=%h required 1,0,0,%h",
                     name, halt, bus.mem_rstrb, retire, bus.mem_addr, addr0);
         end
      end
      $display("program %s halted", name);
   endtask

   initial begin
      RESET = 1'b1;
      clear_mem();
      @(negedge CLK);

      // ADDI x1,x0,5 ; ADD x2,x1,x1 ; ADD x1,x2,x0 ; EBREAK
      clear_mem();
      imem[0] = 32'h0050_0093;
      imem[1] = 32'h0010_8133;
      imem[2] = 32'h0001_00B3;
      do_reset();
      expect_ret(32'd0,  32'd5);
      expect_ret(32'd4,  32'd5);
      expect_ret(32'd8,  32'd10);
      expect_ret(32'd12, 32'd10);
      finish_prog("add");

      // LUI x1,0x80000 ; SRAI x2,x1,4 ; SRLI x3,x1,4 ; ADD x1,x2,x0 ; ADD x1,x3,x0
      clear_mem();
      imem[0] = 32'h8000_00B7;
      imem[1] = 32'h4040_D113;
      imem[2] = 32'h0040_D193;
      imem[3] = 32'h0001_00B3;
      imem[4] = 32'h0001_80B3;
      do_reset();
      expect_ret(32'd0,  32'h8000_0000);
      expect_ret(32'd4,  32'h8000_0000);
      expect_ret(32'd8,  32'h8000_0000);
      expect_ret(32'd12, 32'hF800_0000);
      expect_ret(32'd16, 32'h0800_0000);
      expect_ret(32'd20, 32'h0800_0000);
      finish_prog("shift");

      // ADDI x1,x0,5 ; ADDI x0,x0,7 ; ADD x1,x0,x0
      clear_mem();
      imem[0] = 32'h0050_0093;
      imem[1] = 32'h0070_0013;
      imem[2] = 32'h0000_00B3;
      do_reset();
      expect_ret(32'd0,  32'd5);
      expect_ret(32'd4,  32'd5);
      expect_ret(32'd8,  32'd0);
      expect_ret(32'd12, 32'd0);
      finish_prog("x0");

      // Countdown loop, JAL, then JALR with an odd target
      clear_mem();
      imem[0] = 32'h0030_0093;  // ADDI x1,x0,3
      imem[1] = 32'hFFF0_8093;  // ADDI x1,x1,-1
      imem[2] = 32'hFE00_9EE3;  // BNE  x1,x0,-4
      imem[3] = 32'h0080_00EF;  // JAL  x1,+8
      imem[5] = 32'h0200_0093;  // ADDI x1,x0,0x20
      imem[6] = 32'h0010_8067;  // JALR x0,x1,1
      do_reset();
      expect_ret(32'd0,  32'd3);
      expect_ret(32'd4,  32'd2);
      expect_ret(32'd8,  32'd2);
      expect_ret(32'd4,  32'd1);
      expect_ret(32'd8,  32'd1);
      expect_ret(32'd4,  32'd0);
      expect_ret(32'd8,  32'd0);
      expect_ret(32'd12, 32'd16);
      expect_ret(32'd20, 32'h20);
      expect_ret(32'd24, 32'h20);
      expect_ret(32'h20, 32'h20);
      finish_prog("loop");

      // Reset during EXECUTE of ADDI x1,x0,9 drops the write
      clear_mem();
      imem[0] = 32'h0090_0093;
      do_reset();
      expect_ret(32'd0, 32'd0);
      repeat (3) @(negedge CLK);
      do_reset();
      expect_ret(32'd0, 32'd9);
      expect_ret(32'd4, 32'd9);
      finish_prog("midreset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32i_exec_core.md
# rv32i_exec_core

Multi-cycle RV32I execution core that fetches instruction words from the SOC program memory, decodes them, reads a 32×32 register file, executes ALU, upper-immediate, jump and branch instructions, and writes results back. It is the stage directly downstream of the SOC fetch/decode loop and replaces its "fetch and display only" behaviour with real execution. Load, store and FENCE instructions are retired as no-ops in this block; the memory data path is added in a later block.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address loaded into PC on reset.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET`  in  1  **one clock; reset is synchronous and active-high.**
- `mem_addr`  out  32  byte address of the instruction word; always equals PC.
- `mem_rstrb`  out  1  read strobe; high exactly in the FETCH_INSTR state.
- `mem_rdata`  in  32  instruction word, valid the cycle after `mem_rstrb`.
- `retire`  out  1  one-cycle pulse in each EXECUTE cycle.
- `halt`  out  1  high after a SYSTEM opcode (7'b1110011) has executed.
- `dbg_x1`  out  32  current value of register x1, for the LEDs and bench.

## Operation
- States: FETCH_INSTR → WAIT_INSTR → FETCH_REGS → EXECUTE → FETCH_INSTR; HALT is terminal.
- FETCH_INSTR: assert `mem_rstrb`, with `mem_addr` = PC.
- WAIT_INSTR: latch `mem_rdata` into the instruction register.
- FETCH_REGS: latch rs1 = instr[19:15] and rs2 = instr[24:20] values. Register x0 always reads 0.
- EXECUTE: write back, update PC, pulse `retire`. A SYSTEM opcode goes to HALT instead of FETCH_INSTR.
- Immediates:
  - I: sign-extended instr[31:20].
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
- ALU: operand 2 is rs2 for ALUreg and Iimm for ALUimm. funct3 selects the operation:
  - 000 ADD, or SUB when ALUreg and funct7[5]=1.
  - 001 SLL.
  - 010 SLT (signed).
  - 011 SLTU.
  - 100 XOR.
  - 101 SRL, or SRA when funct7[5]=1.
  - 110 OR.
  - 111 AND.
  - Shift amount is operand-2[4:0]. All arithmetic wraps modulo 2^32.
- Writeback value by instruction:
  - ALU ops: ALU result.
  - LUI: Uimm.
  - AUIPC: PC+Uimm.
  - JAL and JALR: PC+4.
  - Writes to rd = x0 are discarded.
  - Branch, load, store, FENCE, SYSTEM and unknown opcodes write nothing.
- Next PC by instruction:
  - JAL: PC+Jimm.
  - JALR: (rs1+Iimm) & ~1.
  - Taken branch: PC+Bimm.
  - Everything else: PC+4.
  - PC wraps modulo 2^32. Misaligned targets are not trapped; low bits pass to `mem_addr` unchanged.
- Branches: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. funct3 010 and 011 are never taken.
- JALR with rd = rs1 uses the pre-write rs1 value for the target.

## Timing
- Reset, sampled on an edge with RESET=1:
  - PC = RESET_PC, state = FETCH_INSTR.
  - All 32 registers = 0, so `dbg_x1` = 0.
  - `halt` = 0, `retire` = 0, instruction register = 0.
  - While RESET is held: `mem_rstrb` = 1 and `mem_addr` = RESET_PC. Reads have no side effects.
- Every instruction takes exactly 4 cycles. `retire` is high on cycles 3, 7, 11, … after reset release.
- The register write and the PC update both take effect on the rising edge that ends EXECUTE.
- The new rd value is visible to the next instruction's FETCH_REGS, so no hazards exist.
- HALT: `halt`=1 from the edge ending the SYSTEM EXECUTE cycle. After that, `mem_rstrb` = 0, `retire` = 0, and PC and registers are frozen until RESET.
- RESET in any state, including mid-EXECUTE or HALT: the reset values above apply on the next edge. A pending writeback is dropped.

## Test plan
- Execute ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133).
  - `dbg_x1` = 5 from cycle 4.
  - x2 = 10 after cycle 8.
  - `retire` pulses on cycles 3 and 7.
  - `mem_addr` sequence is 0, 4, 8.
- Execute LUI x1,0x80000 (0x800000B7), then SRAI x2,x1,4, then SRLI x3,x1,4.
  - x1 = 0x80000000.
  - x2 = 0xF8000000.
  - x3 = 0x08000000.
- Execute ADDI x0,x0,7, then ADD x1,x0,x0.
  - x1 = 0; x0 is never nonzero.
- Run a countdown loop: ADDI x1,x0,3, then ADDI x1,x1,-1, then BNE x1,x0,-4.
  - The branch is taken twice, then falls through.
  - `dbg_x1` reads 2, 1, 0.
  - PC advances to 12.
- Execute JAL x1,+8 at PC=12.
  - x1 = 16, next `mem_addr` = 20.
- Execute JALR x0,x1,1 with x1 = 0x20.
  - Next `mem_addr` = 0x20 (bit 0 cleared).
- Execute EBREAK (0x00100073).
  - `halt` = 1 and `mem_rstrb` stays 0 for 20 cycles.
  - Assert RESET for one cycle: PC = 0 and `halt` = 0.
  - Asserting RESET during EXECUTE of ADDI x1,x0,9 leaves x1 = 0.
